write_controller: RTL and testbench
===================================

Name: write_controller

Overview:
- Upstream neighbour of the BRAM-to-UART read path. Accepts bytes from the UART receiver and writes them sequentially into port A of the shared 1024x8 true-dual-port BRAM.
- Active only while the top-level master FSM is in the LOAD phase. Reports completion to the master with write_done, and a transport fault with write_error.
- Also produces a byte count and an 8-bit running checksum for the master and the processing stage.

Parameters:
- DEPTH, 1024, number of bytes in one complete frame (BRAM depth).
- ADDR_W, 10, BRAM address width; must equal $clog2(DEPTH).
- DATA_W, 8, byte width.
- TIMEOUT_CYC, 2000000, idle clock cycles allowed between bytes once a frame has started; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- master_state  input  2  master FSM phase; this block acts only when the value equals M_LOAD.
- rx_data  input  DATA_W  received byte; valid when rx_ready=1.
- rx_ready  input  1  one-cycle strobe from the UART receiver, one per byte.
- wea  output  1  BRAM port A write enable.
- addra  output  ADDR_W  BRAM port A address.
- dina  output  DATA_W  BRAM port A write data.
- write_done  output  1  full frame stored; held while master_state==M_LOAD.
- write_error  output  1  inter-byte timeout fired; held while master_state==M_LOAD.
- bytes_rcvd  output  ADDR_W+1  bytes written in the current frame, range 0..DEPTH.
- checksum  output  DATA_W  modulo-2^DATA_W sum of the bytes written in the current frame.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. wea, addra, dina, write_done, write_error, bytes_rcvd, checksum and the timeout counter all go to 0.
- All outputs are registered.
- FSM states: IDLE, RECV, DONE, ERR.
- IDLE → RECV when master_state==M_LOAD. On this transition bytes_rcvd, checksum and the timer are cleared.
- RECV, on rx_ready=1 at edge N, the following hold in the cycle after edge N:
  - wea=1, addra=bytes_rcvd(old), dina=rx_data.
  - bytes_rcvd is incremented.
  - checksum = checksum + rx_data, truncated to DATA_W bits.
  - the timer is cleared.
- wea is high for exactly one cycle per accepted byte. rx_ready on consecutive cycles is accepted every cycle, giving back-to-back wea pulses. No byte is ever dropped in RECV.
- RECV → DONE on the edge after the write of byte DEPTH-1. write_done rises one cycle after the final wea cycle.
- DONE: further rx_ready strobes are ignored. wea stays 0 and the counters are frozen.
- Timeout, in RECV with bytes_rcvd>0 and TIMEOUT_CYC≠0:
  - the timer counts every cycle without rx_ready;
  - when it reaches TIMEOUT_CYC, the FSM goes RECV → ERR and write_error=1.
  - Before the first byte of a frame there is no timeout.
- ERR: rx_ready is ignored, wea=0, and bytes_rcvd/checksum are frozen for diagnosis.
- Any state except IDLE: if master_state≠M_LOAD, the FSM returns to IDLE on the next edge.
  - write_done, write_error and wea are cleared on that edge.
  - bytes_rcvd and checksum hold their values until the next LOAD entry.
  - This is the abort path when the master leaves LOAD mid-transfer; write_done is never asserted for a partial frame.
- If master_state leaves M_LOAD on the same edge that rx_ready is sampled, abort wins: no write occurs.
- addra never exceeds DEPTH-1. There is no address wrap-around, because the FSM leaves RECV at DEPTH bytes.
- Timer width is $clog2(TIMEOUT_CYC+1). When TIMEOUT_CYC=0 the timer logic is tied off.

Decomposition:
- Shared package ctrl_pkg:
  - master_state encoding: M_IDLE=2'd0, M_SEND=2'd1, M_LOAD=2'd2, M_PROC=2'd3;
  - the write_controller state typedef;
  - localparam BRAM_DEPTH=1024 and BRAM_ADDR_W=10.
  - The read path's master_state comparisons must use the same package.
- One sub-module, idle_timer: a loadable/clearable down-counter with a terminal pulse, reusable by the read path.

Test Plan:
- Full frame with DEPTH=16 override: master_state=M_LOAD, 16 strobes with bytes 1..16 spaced 10 cycles apart → 16 single-cycle wea pulses at addra 0..15 with dina=1..16. Then bytes_rcvd=16, checksum=0x88, and write_done=1 one cycle after the last wea.
- Back-to-back strobes: rx_ready high for 4 consecutive cycles with bytes 0xA0..0xA3 → wea high 4 consecutive cycles at addra 0..3 with the matching dina; bytes_rcvd=4.
- Abort: after 5 bytes, set master_state=M_IDLE → wea=0 and write_done=0. Re-enter M_LOAD → bytes_rcvd=0 and the next byte is written at addra=0.
- Timeout with TIMEOUT_CYC=50: send 3 bytes, then stay silent → write_error=1 exactly 50 cycles after the 3rd accepted strobe; bytes_rcvd=3; a later rx_ready gives no wea.
- Overrun after done: send 2 extra bytes after 16 → no wea, checksum stays 0x88, write_done stays high until master_state≠M_LOAD.
- Async reset mid-frame: pull rst=0 between clock edges after 7 bytes → all outputs 0 immediately. After release with master_state=M_LOAD, a fresh frame starts at addra=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the BRAM load/unload paths: master FSM
// phase encoding, write-controller state type and BRAM geometry.
package ctrl_pkg;

  // Top-level master FSM phase, as driven on master_state.
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_SEND = 2'd1,
    M_LOAD = 2'd2,
    M_PROC = 2'd3
  } master_state_e;

  // Write-controller FSM states.
  typedef enum logic [1:0] {
    WC_IDLE = 2'd0,
    WC_RECV = 2'd1,
    WC_DONE = 2'd2,
    WC_ERR  = 2'd3
  } wc_state_e;

  localparam int BRAM_DEPTH  = 1024;
  localparam int BRAM_ADDR_W = 10;

  // True when the master is in the given phase; keeps every block comparing
  // master_state against the same encoding.
  function automatic logic master_is(input logic [1:0] ms, input master_state_e ph);
    return ms == 2'(ph);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Loadable down-counter used as an inactivity watchdog. load_i reloads the
// count, en_i lets it count down by one per cycle and it parks at zero.
// tc_o flags a count of one: the next enabled cycle is the expiry cycle, so
// a caller that sees (en && tc_o) knows the limit is reached on that edge.
module idle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload wins over counting; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/write_controller.sv
// Receives bytes from the UART receiver during the master LOAD phase and
// writes them sequentially into BRAM port A. Tracks the byte count and a
// modulo-2^DATA_W checksum, flags frame completion and inter-byte timeouts.
// Leaving LOAD aborts from any state; the counters are kept for inspection
// until the next LOAD entry.
module write_controller
  import ctrl_pkg::*;
#(
  parameter int DEPTH       = BRAM_DEPTH,
  parameter int ADDR_W      = BRAM_ADDR_W,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        master_state,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              write_done,
  output logic              write_error,
  output logic [ADDR_W:0]   bytes_rcvd,
  output logic [DATA_W-1:0] checksum
);

  // Timer width covers 0..TIMEOUT_CYC; kept at least one bit when disabled.
  localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  wc_state_e         state_q, state_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  logic              in_load;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_tc;

  assign in_load = master_is(master_state, M_LOAD);

  // Inactivity timer, only present when a timeout is configured.
  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      idle_timer #(
        .W(TMR_W)
      ) u_idle_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(TIMEOUT_CYC)),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
      );
    end else begin : g_no_timer
      logic unused_tmr;
      assign unused_tmr = tmr_load ^ tmr_en;
      assign tmr_tc     = 1'b0;
    end
  endgenerate

  // Next-state and output logic. Priority inside RECV: abort, frame full,
  // byte accept, then timeout.
  always_comb begin
    state_d  = state_q;
    wea_d    = 1'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    done_d   = done_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      WC_IDLE: begin
        done_d = 1'b0;
        err_d  = 1'b0;
        if (in_load) begin
          state_d  = WC_RECV;
          cnt_d    = '0;
          sum_d    = '0;
          tmr_load = 1'b1;
        end
      end

      WC_RECV: begin
        if (!in_load) begin
          state_d = WC_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (cnt_q == FULL_CNT) begin
          // Final write went out last cycle; report completion now.
          state_d = WC_DONE;
          done_d  = 1'b1;
        end else if (rx_ready) begin
          wea_d    = 1'b1;
          addra_d  = cnt_q[ADDR_W-1:0];
          dina_d   = rx_data;
          cnt_d    = cnt_q + 1'b1;
          sum_d    = sum_q + rx_data;
          tmr_load = 1'b1;
        end else if (cnt_q != '0) begin
          // Timeout only runs once the frame has started.
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d = WC_ERR;
            err_d   = 1'b1;
          end
        end
      end

      WC_DONE, WC_ERR: begin
        if (!in_load) begin
          state_d = WC_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = WC_IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WC_IDLE;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign wea         = wea_q;
  assign addra       = addra_q;
  assign dina        = dina_q;
  assign write_done  = done_q;
  assign write_error = err_q;
  assign bytes_rcvd  = cnt_q;
  assign checksum    = sum_q;

endmodule

// File: tb/tb_write_controller.sv
// Bench for write_controller with a 16-byte frame and a 50-cycle timeout.
module tb_write_controller;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int TMO    = 50;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_LOAD = 2'd2;

  logic              clk;
  logic              rst;
  logic [1:0]        master_state;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              write_done;
  logic              write_error;
  logic [ADDR_W:0]   bytes_rcvd;
  logic [DATA_W-1:0] checksum;

  write_controller #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master_state (master_state),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .wea          (wea),
    .addra        (addra),
    .dina         (dina),
    .write_done   (write_done),
    .write_error  (write_error),
    .bytes_rcvd   (bytes_rcvd),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
    int         exp_cnt;
    logic [7:0] exp_sum;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  vec_t       vecs[DEPTH];
  wr_t        sb[$];
  int         n_cmp;
  int         n_fail;
  int         m_cnt;
  logic [7:0] m_sum;
  int         fire_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and check any write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wea) begin
      if (sb.size() == 0) begin
        chk("wea_unexpected", 32'(wea), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("addra", 32'(addra), 32'(e.addr));
        chk("dina", 32'(dina), 32'(e.data));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit expect_write);
    if (expect_write) begin
      sb.push_back('{addr: m_cnt[ADDR_W-1:0], data: d});
      m_cnt++;
      m_sum = m_sum + d;
    end
    rx_data  = d;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    if (expect_write) chk("wea_seen", 32'(sb.size()), 32'd0);
  endtask

  task automatic new_frame();
    master_state = MS_LOAD;
    tick();
    m_cnt = 0;
    m_sum = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [7:0] run;
    n_cmp        = 0;
    n_fail       = 0;
    m_cnt        = 0;
    m_sum        = 8'h00;
    rst          = 1'b0;
    master_state = MS_IDLE;
    rx_data      = 8'h00;
    rx_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_addra", 32'(addra), 32'd0);
    chk("rst_dina", 32'(dina), 32'd0);
    chk("rst_done", 32'(write_done), 32'd0);
    chk("rst_error", 32'(write_error), 32'd0);
    chk("rst_bytes", 32'(bytes_rcvd), 32'd0);
    chk("rst_sum", 32'(checksum), 32'd0);
    rst = 1'b1;
    tick();

    // Full frame: bytes 1..16, 10 cycles apart
    run = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      vecs[i].data    = 8'(i + 1);
      vecs[i].gap     = 9;
      run             = run + 8'(i + 1);
      vecs[i].exp_cnt = i + 1;
      vecs[i].exp_sum = run;
    end
    new_frame();
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(vecs[i].data, 1'b1);
      chk("frame_bytes", 32'(bytes_rcvd), 32'(vecs[i].exp_cnt));
      chk("frame_sum", 32'(checksum), 32'(vecs[i].exp_sum));
      chk("done_early", 32'(write_done), 32'd0);
      if (i == DEPTH - 1) begin
        tick();
        chk("write_done", 32'(write_done), 32'd1);
      end
      repeat (vecs[i].gap) tick();
    end
    chk("frame_total_sum", 32'(checksum), 32'h88);
    chk("frame_total_cnt", 32'(bytes_rcvd), 32'd16);

    // Overrun after done
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEF, 1'b0);
    chk("overrun_sum", 32'(checksum), 32'h88);
    chk("overrun_cnt", 32'(bytes_rcvd), 32'd16);
    chk("overrun_done", 32'(write_done), 32'd1);
    master_state = MS_IDLE;
    tick();
    chk("done_clear", 32'(write_done), 32'd0);
    chk("idle_hold_cnt", 32'(bytes_rcvd), 32'd16);

    // Back-to-back strobes
    new_frame();
    chk("b2b_clr_cnt", 32'(bytes_rcvd), 32'd0);
    chk("b2b_clr_sum", 32'(checksum), 32'd0);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{addr: m_cnt[ADDR_W-1:0], data: 8'(8'hA0 + k)});
      m_cnt++;
      m_sum    = m_sum + 8'(8'hA0 + k);
      rx_data  = 8'(8'hA0 + k);
      rx_ready = 1'b1;
      tick();
      chk("b2b_wea", 32'(wea), 32'd1);
    end
    rx_ready = 1'b0;
    tick();
    chk("b2b_cnt", 32'(bytes_rcvd), 32'd4);
    chk("b2b_sum", 32'(checksum), 32'(m_sum));

    // Abort after 5 bytes, with a strobe on the abort edge
    send_byte(8'h3C, 1'b1);
    chk("abort_pre_cnt", 32'(bytes_rcvd), 32'd5);
    master_state = MS_IDLE;
    rx_data      = 8'h77;
    rx_ready     = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("abort_wea", 32'(wea), 32'd0);
    chk("abort_done", 32'(write_done), 32'd0);
    chk("abort_hold_cnt", 32'(bytes_rcvd), 32'd5);
    tick();
    new_frame();
    chk("reenter_cnt", 32'(bytes_rcvd), 32'd0);
    repeat (60) tick();
    chk("no_timeout_before_first", 32'(write_error), 32'd0);
    send_byte(8'h55, 1'b1);
    chk("reenter_first_cnt", 32'(bytes_rcvd), 32'd1);

    // Timeout: 3 bytes then silence
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    fire_at = -1;
    for (int k = 1; k <= TMO + 10; k++) begin
      tick();
      if (write_error && fire_at < 0) fire_at = k;
    end
    chk("timeout_cycles", 32'(fire_at), 32'(TMO));
    chk("timeout_cnt", 32'(bytes_rcvd), 32'd3);
    send_byte(8'h99, 1'b0);
    chk("err_hold_cnt", 32'(bytes_rcvd), 32'd3);
    chk("err_hold_flag", 32'(write_error), 32'd1);
    master_state = MS_IDLE;
    tick();
    chk("err_clear", 32'(write_error), 32'd0);

    // Async reset mid-frame after 7 bytes, with wea still high
    new_frame();
    for (int k = 0; k < 6; k++) send_byte(8'(8'h40 + k), 1'b1);
    sb.push_back('{addr: m_cnt[ADDR_W-1:0], data: 8'h46});
    m_cnt++;
    rx_data  = 8'h46;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("pre_rst_cnt", 32'(bytes_rcvd), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("async_wea", 32'(wea), 32'd0);
    chk("async_addra", 32'(addra), 32'd0);
    chk("async_dina", 32'(dina), 32'd0);
    chk("async_cnt", 32'(bytes_rcvd), 32'd0);
    chk("async_sum", 32'(checksum), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    m_cnt = 0;
    m_sum = 8'h00;
    send_byte(8'hC3, 1'b1);
    chk("post_rst_cnt", 32'(bytes_rcvd), 32'd1);
    chk("post_rst_sum", 32'(checksum), 32'hC3);
    master_state = MS_IDLE;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
